// File: rtl/egress_port_scheduler_pkg.sv
// egress_port_scheduler_pkg: shared state encoding and byte-stream constants for the egress scheduler.
//   DATA_WIDTH    - width of a forwarded byte including the end-of-frame flag
//   LAST_BYTE_BIT - position of the end-of-frame flag inside a byte
package egress_scheduler_package;
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    localparam int DATA_WIDTH = 9;
    localparam int LAST_BYTE_BIT = 8;
endpackage

// File: rtl/egress_port_scheduler_if.sv
// egress_port_scheduler_if: requester and egress handshake bundle of one egress port.
//   request/request_data/request_data_valid  - per-requester frame request and byte stream
//   request_data_ready/grant                 - per-requester ready and one-hot grant
//   egress_data/egress_data_valid/egress_ready - forwarded byte stream to the transmitter
//   busy/frame_abort                         - scheduler status
//   modport slave is the scheduler, modport master is the requester/transmitter side.
interface egress_port_scheduler_if
    import egress_scheduler_package::*;
#(
    parameter int N = 3
);
    logic [N-1:0]                 request;
    logic [N-1:0][DATA_WIDTH-1:0] request_data;
    logic [N-1:0]                 request_data_valid;
    logic [N-1:0]                 request_data_ready;
    logic [N-1:0]                 grant;
    logic [DATA_WIDTH-1:0]        egress_data;
    logic                         egress_data_valid;
    logic                         egress_ready;
    logic                         busy;
    logic                         frame_abort;

    modport slave (
        input  request, request_data, request_data_valid, egress_ready,
        output request_data_ready, grant, egress_data, egress_data_valid, busy, frame_abort
    );

    modport master (
        output request, request_data, request_data_valid, egress_ready,
        input  request_data_ready, grant, egress_data, egress_data_valid, busy, frame_abort
    );
endinterface

// File: rtl/egress_port_scheduler_round_robin_arbiter.sv
// round_robin_arbiter: combinational pick of the first requester after the last-grant pointer.
//   request_i - request levels
//   pointer_i - index of the last round-robin grant
//   grant_o   - one-hot pick (zero when nothing requests)
//   pointer_o - index of the pick, or pointer_i when nothing requests
module round_robin_arbiter #(
    parameter int N = 3,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  request_i,
    input  logic [PW-1:0] pointer_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] pointer_o
);
    logic [PW-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest requester wins.
    always_comb begin
        grant_o = '0;
        pointer_o = pointer_i;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            idx = PW'((int'(pointer_i) + i) % N);
            if (request_i[idx]) begin
                grant_o = N'(1) << idx;
                pointer_o = idx;
            end
        end
    end
endmodule

// File: rtl/egress_port_scheduler.sv
// egress_port_scheduler: round-robin frame scheduler sharing one egress transmit path between requesters.
//   clock   - core clock
//   reset_n - asynchronous active-low reset
//   bus     - requester/egress handshake bundle (slave side)
// Optional: EGRESS_SCHEDULER_VIRTUAL_PRIORITY_EN gives requester N-1 priority over the round-robin.
module egress_port_scheduler
    import egress_scheduler_package::*;
#(
    parameter int NUMBER_OF_REQUESTERS   = 3,
    parameter int INTER_FRAME_GAP_CYCLES = 96,
    parameter int MAX_FRAME_BYTES        = 1522,
    parameter int STALL_TIMEOUT_CYCLES   = 256
) (
    input logic                    clock,
    input logic                    reset_n,
    egress_port_scheduler_if.slave bus
);
    localparam int N  = NUMBER_OF_REQUESTERS;
    localparam int PW = $clog2(N);
    localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int SW = $clog2(STALL_TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(INTER_FRAME_GAP_CYCLES + 1);

    state_t                state_q, state_d;
    logic [N-1:0]          grant_q, grant_d;
    logic [PW-1:0]         pointer_q, pointer_d, select_q, select_d;
    logic [BW-1:0]         bytes_q, bytes_d;
    logic [SW-1:0]         stall_q, stall_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d, abort_q, abort_d;
    logic [N-1:0]          arb_grant;
    logic [PW-1:0]         arb_pointer;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] in_data;

    round_robin_arbiter #(.N(N)) u_arbiter (
        .request_i (bus.request),
        .pointer_i (pointer_q),
        .grant_o   (arb_grant),
        .pointer_o (arb_pointer)
    );

    // grant_q is zero outside GRANT, so ready needs no state term.
    assign bus.request_data_ready = grant_q & {N{!valid_q | bus.egress_ready}};
    assign transfer = |(bus.request_data_ready & bus.request_data_valid);
    assign in_data = bus.request_data[select_q];

    assign bus.grant = grant_q;
    assign bus.egress_data = data_q;
    assign bus.egress_data_valid = valid_q;
    assign bus.busy = state_q != IDLE;
    assign bus.frame_abort = abort_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        pointer_d = pointer_q;
        select_d = select_q;
        bytes_d = bytes_q;
        stall_d = stall_q;
        gap_d = gap_q;
        abort_d = 1'b0;
        // The output register drains in every state; only GRANT can refill it.
        data_d = transfer ? in_data : data_q;
        valid_d = transfer | (valid_q & !bus.egress_ready);
        case (state_q)
            IDLE: begin
                if (|bus.request) begin
`ifdef EGRESS_SCHEDULER_VIRTUAL_PRIORITY_EN
                    if (bus.request[N-1]) begin
                        grant_d = N'(1) << (N - 1);
                        select_d = PW'(N - 1);
                    end else begin
                        grant_d = arb_grant;
                        pointer_d = arb_pointer;
                        select_d = arb_pointer;
                    end
`else
                    grant_d = arb_grant;
                    pointer_d = arb_pointer;
                    select_d = arb_pointer;
`endif
                    bytes_d = '0;
                    stall_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                bytes_d = transfer ? bytes_q + 1'b1 : bytes_q;
                stall_d = transfer ? '0 : (stall_q == SW'(STALL_TIMEOUT_CYCLES)) ? stall_q : stall_q + 1'b1;
                // A last byte takes precedence over a simultaneous length or stall limit.
                if ((transfer && in_data[LAST_BYTE_BIT]) || bytes_d == BW'(MAX_FRAME_BYTES)
                    || stall_d == SW'(STALL_TIMEOUT_CYCLES)) begin
                    abort_d = !(transfer && in_data[LAST_BYTE_BIT]);
                    grant_d = '0;
                    gap_d = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                state_d = (gap_d == GW'(INTER_FRAME_GAP_CYCLES)) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            pointer_q <= PW'(N - 1);
            select_q <= '0;
            bytes_q <= '0;
            stall_q <= '0;
            gap_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pointer_q <= pointer_d;
            select_q <= select_d;
            bytes_q <= bytes_d;
            stall_q <= stall_d;
            gap_q <= gap_d;
            data_q <= data_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
        end
    end
endmodule

// File: tb/tb_egress_port_scheduler.sv
// tb_egress_port_scheduler: randomized frame sources checked every cycle against a frame-level scheduler model.
module tb_egress_port_scheduler;
    import egress_scheduler_package::*;
    localparam int N = 3;
    localparam int GAPC = 96;
    localparam int MAXB = 1522;
    localparam int STALL = 256;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    egress_port_scheduler_if #(.N(N)) bus ();

    egress_port_scheduler #(
        .NUMBER_OF_REQUESTERS   (N),
        .INTER_FRAME_GAP_CYCLES (GAPC),
        .MAX_FRAME_BYTES        (MAXB),
        .STALL_TIMEOUT_CYCLES   (STALL)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Source configuration and progress.
    int len [N];
    int pos [N];
    int left [N];
    int sent [N];
    int vprob [N];
    int stall_pos [N];
    bit nolast [N];
    int erprob = 100;
    bit er_low = 1'b0;
    logic [N-1:0] hs = '0;
    bit abort_seen = 1'b0;
    int owner_seen = -1;

    // Reference model.
    int m_owner = -1;
    int m_gap = 0;
    int m_ptr = N - 1;
    int m_bytes = 0;
    int m_stall = 0;
    bit m_abort = 1'b0;
    bit m_v = 1'b0;
    logic [DATA_WIDTH-1:0] m_d = '0;

    // Observations for literal checks.
    logic [N-1:0] prev_grant = '0;
    int rise_q [$];
    int gap_at_rise [$];
    int dist_at_rise [$];
    int fall_cyc = -1;
    int gap_run = 0;
    int aborts = 0;
    int accepted = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sources: one byte presented per requester, advancing after each accepted byte.
    initial begin : driver
        bus.request = '0;
        bus.request_data = '0;
        bus.request_data_valid = '0;
        bus.egress_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    pos[i]++;
                    if (pos[i] >= len[i]) begin
                        pos[i] = 0;
                        sent[i]++;
                        if (left[i] > 0) left[i]--;
                    end
                end
                if (abort_seen && owner_seen == i && pos[i] != 0) begin
                    pos[i] = 0;
                    stall_pos[i] = -1;
                    if (left[i] > 0) left[i]--;
                end
                bus.request[i] = left[i] > 0;
                bus.request_data_valid[i] = left[i] > 0 && pos[i] != stall_pos[i]
                                            && int'($urandom_range(99)) < vprob[i];
                bus.request_data[i] = {pos[i] == len[i] - 1 && !nolast[i], 8'(i * 67 + pos[i] * 13 + sent[i] * 7)};
            end
            bus.egress_ready = !er_low && int'($urandom_range(99)) < erprob;
        end
    end

    // Per-cycle compare against the model, then advance the model with this cycle's inputs.
    initial begin : compare
        logic [N-1:0] exp_grant;
        bit xfer;
        int pick;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                m_owner = -1;
                m_gap = 0;
                m_ptr = N - 1;
                m_bytes = 0;
                m_stall = 0;
                m_abort = 1'b0;
                m_v = 1'b0;
                prev_grant = '0;
                hs = '0;
                abort_seen = 1'b0;
            end else begin
                exp_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
                chk("grant", bus.grant, exp_grant);
                chk("busy", bus.busy, m_owner >= 0 || m_gap > 0);
                chk("frame_abort", bus.frame_abort, m_abort);
                chk("ready", bus.request_data_ready, (m_owner >= 0 && (!m_v || bus.egress_ready)) ? exp_grant : '0);
                chk("egress_valid", bus.egress_data_valid, m_v);
                if (m_v) chk("egress_data", bus.egress_data, m_d);
                // Monitor.
                if (bus.grant != '0 && prev_grant == '0) begin
                    for (int j = 0; j < N; j++) if (bus.grant[j]) rise_q.push_back(j);
                    gap_at_rise.push_back(gap_run);
                    dist_at_rise.push_back(fall_cyc < 0 ? -1 : cyc - fall_cyc);
                end
                if (bus.grant == '0 && prev_grant != '0) begin
                    fall_cyc = cyc;
                    gap_run = 0;
                end
                if (bus.grant == '0 && bus.busy) gap_run++;
                if (bus.frame_abort) aborts++;
                if (bus.egress_data_valid && bus.egress_ready) accepted++;
                for (int j = 0; j < N; j++) if (bus.grant[j]) owner_seen = j;
                hs = bus.request_data_valid & bus.request_data_ready;
                abort_seen = bus.frame_abort;
                prev_grant = bus.grant;
                // Model step.
                xfer = m_owner >= 0 && bus.request_data_valid[m_owner] && (!m_v || bus.egress_ready);
                m_abort = 1'b0;
                if (m_owner >= 0) begin
                    if (xfer) begin
                        m_d = bus.request_data[m_owner];
                        m_bytes++;
                        m_stall = 0;
                    end else begin
                        m_stall++;
                    end
                    if (xfer && m_d[LAST_BYTE_BIT]) begin
                        m_owner = -1;
                        m_gap = GAPC;
                    end else if (m_bytes == MAXB || m_stall == STALL) begin
                        m_owner = -1;
                        m_gap = GAPC;
                        m_abort = 1'b1;
                    end
                end else if (m_gap > 0) begin
                    m_gap--;
                end else if (bus.request != '0) begin
                    pick = -1;
`ifdef EGRESS_SCHEDULER_VIRTUAL_PRIORITY_EN
                    if (bus.request[N-1]) pick = N - 1;
`endif
                    if (pick < 0) begin
                        for (int k = 1; k <= N; k++)
                            if (pick < 0 && bus.request[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                        m_ptr = pick;
                    end
                    m_owner = pick;
                    m_bytes = 0;
                    m_stall = 0;
                end
                if (xfer) m_v = 1'b1;
                else if (bus.egress_ready) m_v = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic src(input int i, input int frames, input int length, input int vp, input bit nl);
        left[i] = frames;
        len[i] = length;
        vprob[i] = vp;
        nolast[i] = nl;
        pos[i] = 0;
    endtask

    task automatic clear_mon();
        rise_q.delete();
        gap_at_rise.delete();
        dist_at_rise.delete();
        aborts = 0;
        accepted = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = !bus.busy && !bus.egress_data_valid;
            for (int i = 0; i < N; i++) if (left[i] != 0) done = 1'b0;
        end
        chk("drain_in_time", done, 1);
    endtask

    task automatic wait_accept(input int target, input int budget);
        int n = 0;
        while (accepted < target && n < budget) begin
            tick();
            n++;
        end
        chk("accept_in_time", accepted >= target, 1);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            pos[i] = 0;
        end
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    initial begin : main
        logic [DATA_WIDTH-1:0] held;
        int total;
        for (int i = 0; i < N; i++) begin
            len[i] = 1;
            pos[i] = 0;
            left[i] = 0;
            sent[i] = 0;
            vprob[i] = 100;
            stall_pos[i] = -1;
            nolast[i] = 1'b0;
        end
        #1 reset_n = 1'b0;
        #1;
        chk("reset_grant", bus.grant, 0);
        chk("reset_valid", bus.egress_data_valid, 0);
        chk("reset_data", bus.egress_data, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_abort", bus.frame_abort, 0);
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        tick();

        // Two 4-byte frames, back to back with a full gap.
        clear_mon();
        erprob = 100;
        src(0, 1, 4, 100, 0);
        src(1, 1, 4, 100, 0);
        drain(500);
        chk("t1_grants", rise_q.size(), 2);
        if (rise_q.size() == 2) begin
            chk("t1_first", rise_q[0], 0);
            chk("t1_second", rise_q[1], 1);
            chk("t1_gap", gap_at_rise[1], GAPC);
            chk("t1_fall_to_grant", dist_at_rise[1], GAPC + 1);
        end
        chk("t1_bytes", accepted, 8);

        // Arbitration order with all three requesting.
        pulse_reset();
        clear_mon();
        src(0, 2, 2, 100, 0);
        src(1, 2, 2, 100, 0);
        src(2, 3, 2, 100, 0);
        drain(2000);
        chk("t2_grants", rise_q.size(), 7);
        if (rise_q.size() >= 4) begin
`ifdef EGRESS_SCHEDULER_VIRTUAL_PRIORITY_EN
            chk("t2_order0", rise_q[0], 2);
            chk("t2_order1", rise_q[1], 2);
            chk("t2_order2", rise_q[2], 2);
            chk("t2_order3", rise_q[3], 0);
`else
            chk("t2_order0", rise_q[0], 0);
            chk("t2_order1", rise_q[1], 1);
            chk("t2_order2", rise_q[2], 2);
            chk("t2_order3", rise_q[3], 0);
`endif
        end
        chk("t2_bytes", accepted, 14);

        // Egress backpressure for 5 cycles mid-frame.
        clear_mon();
        src(0, 1, 10, 100, 0);
        wait_accept(3, 200);
        er_low = 1'b1;
        tick();
        held = bus.egress_data;
        repeat (5) begin
            chk("hold_valid", bus.egress_data_valid, 1);
            chk("hold_data", bus.egress_data, held);
            chk("hold_ready", bus.request_data_ready, 0);
            tick();
        end
        er_low = 1'b0;
        drain(500);
        chk("t3_bytes", accepted, 10);
        chk("t3_aborts", aborts, 0);

        // Stall timeout.
        clear_mon();
        stall_pos[0] = 3;
        src(0, 1, 8, 100, 0);
        drain(1000);
        chk("t4_aborts", aborts, 1);
        chk("t4_bytes", accepted, 3);

        // Length limit without and with an end marker on byte 1522.
        clear_mon();
        src(0, 1, MAXB, 100, 1);
        drain(5000);
        chk("t5_abort_nolast", aborts, 1);
        chk("t5_bytes_nolast", accepted, MAXB);
        clear_mon();
        src(0, 1, MAXB, 100, 0);
        drain(5000);
        chk("t5_abort_last", aborts, 0);
        chk("t5_bytes_last", accepted, MAXB);

        // Randomized traffic and backpressure.
        for (int r = 0; r < 3; r++) begin
            clear_mon();
            erprob = 60;
            total = 0;
            for (int i = 0; i < N; i++) begin
                src(i, 3, int'($urandom_range(6, 1)), 60, 0);
                total += 3 * len[i];
            end
            drain(6000);
            chk("rand_bytes", accepted, total);
            chk("rand_aborts", aborts, 0);
        end
        erprob = 100;

        // Reset mid-frame.
        clear_mon();
        src(0, 2, 20, 100, 0);
        src(1, 2, 20, 100, 0);
        wait_accept(5, 200);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_valid", bus.egress_data_valid, 0);
        chk("rst_data", bus.egress_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_abort", bus.frame_abort, 0);
        chk("rst_ready", bus.request_data_ready, 0);
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            pos[i] = 0;
        end
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        tick();
        clear_mon();
        src(0, 1, 3, 100, 0);
        src(1, 1, 3, 100, 0);
        drain(500);
        chk("t7_grants", rise_q.size(), 2);
        if (rise_q.size() >= 1) chk("t7_first", rise_q[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
